// File: rtl/branch_compare_unit.sv
// Branch compare unit: one-entry registered result stage comparing two operands.
// Optional taken-result statistics counter is built when BCU_STATS_EN is defined.
module branch_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_illegal
`ifdef BCU_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_count
`endif
);

    typedef struct packed {
        logic taken;
        logic illegal;
    } result_t;

    result_t res_d, res_q;
    logic    valid_q;
    logic    accept, deliver;
    logic    eq, lt_s, lt_u;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = valid_q && out_ready;

    assign eq   = (in1 == in2);
    assign lt_s = ($signed(in1) < $signed(in2));
    assign lt_u = (in1 < in2);

    // mode[2] picks relational vs equality, mode[1] unsigned, mode[0] inverts.
    always_comb begin
        res_d = '0;
        if (mode[2:1] == 2'b01) begin
            res_d.illegal = 1'b1;
        end else if (!mode[2]) begin
            res_d.taken = eq ^ mode[0];
        end else begin
            res_d.taken = (mode[1] ? lt_u : lt_s) ^ mode[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
        end else if (deliver) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign out_taken   = res_q.taken;
    assign out_illegal = res_q.illegal;

`ifdef BCU_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (deliver && res_q.taken && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign taken_count = cnt_q;
`endif

endmodule

// File: doc/branch_compare_unit.md
BRANCH_COMPARE_UNIT -- requirements
Module: branch_compare_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL provide parameter CNT_W, default 16, width of the taken-statistics counter.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  operand pair and mode present.
REQ-006 SHALL provide port in_ready  output  1  unit can accept an operand pair this cycle.
REQ-007 SHALL provide port in1  input  WIDTH  first operand (rs).
REQ-008 SHALL provide port in2  input  WIDTH  second operand (rt).
REQ-009 SHALL provide port mode  input  3  compare mode: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 reserved.
REQ-010 SHALL provide port out_valid  output  1  registered result present.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts result this cycle.
REQ-012 SHALL provide port out_taken  output  1  compare result (1 = branch taken).
REQ-013 SHALL provide port out_illegal  output  1  result came from a reserved mode.
REQ-014 SHALL provide port taken_count  output  CNT_W  saturating count of delivered taken results (present only with BCU_STATS_EN).

Function
REQ-015 SHALL hold one result register; in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL accept an input when in_valid && in_ready; result appears with out_valid=1 on the next rising edge (latency 1 cycle).
REQ-017 SHALL complete the output handshake when out_valid && out_ready; with no simultaneous accept, out_valid clears next cycle.
REQ-018 Simultaneous handshake and accept SHALL replace the result with the new one, out_valid staying 1 (full throughput, no bubble).
REQ-019 While out_valid && !out_ready, out_taken and out_illegal SHALL hold stable and no input SHALL be accepted.
REQ-020 EQ/NE SHALL compare all WIDTH bits; LT/GE SHALL use two's-complement signed order; LTU/GEU unsigned order.
REQ-021 Reserved modes SHALL produce out_taken=0, out_illegal=1; legal modes produce out_illegal=0.
REQ-022 Inputs with in_valid=0 SHALL NOT affect any state, regardless of in1/in2/mode values.

Reset
REQ-023 reset=1 SHALL force out_valid=0, out_taken=0, out_illegal=0, taken_count=0 on the next edge.
REQ-024 Reset SHALL override any concurrent accept or handshake; a pending result is discarded, not delivered.
REQ-025 in_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-026 Macro BCU_STATS_EN defined: taken_count port and counter present; increments by 1 on each output handshake with out_taken=1, saturating at all-ones.
REQ-027 Macro BCU_STATS_EN undefined: taken_count port and counter absent; all other behaviour identical.

Verification
REQ-028 WIDTH=32, mode=000, in1=in2=32'h00000010, out_ready=1 -> next cycle out_valid=1, out_taken=1, out_illegal=0.
REQ-029 mode=100, in1=32'hFFFFFFFF, in2=32'h00000001 -> out_taken=1; same operands mode=110 -> out_taken=0.
REQ-030 out_ready=0 for 3 cycles after first result, in_valid=1 held -> in_ready=0, outputs stable; out_ready=1 -> back-to-back results, one per cycle, no loss or duplication.
REQ-031 mode=010, in1=in2=0 -> out_taken=0, out_illegal=1; taken_count unchanged.
REQ-032 BCU_STATS_EN, CNT_W=2, five delivered taken results -> taken_count = 3 (saturated); reset -> 0.
REQ-033 reset asserted while out_valid=1, out_ready=0 -> next cycle out_valid=0, no handshake observed, taken_count unchanged by the discarded result.
